// File: rtl/ysyx_23060061_pkg.sv
// Shared types and constants for the NPC fetch/execute sequencer.
package ysyx_23060061_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_EXEC = 3'd3,
    S_HALT = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060061_Reg.sv
// Generic register with write enable and async active-low reset to RESET_VAL.
module ysyx_23060061_Reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wen_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) dout_o <= RESET_VAL;
    else if (wen_i) dout_o <= din_i;
  end

endmodule

// File: rtl/ysyx_23060061_fetch_timer.sv
// Fetch watchdog: counts REQ/WAIT cycles; expire_o flags the TIMEOUT_CYCLES-th counted cycle.
// Combinational expire, no backpressure; clear has priority over enable.
module ysyx_23060061_fetch_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of cycles already spent, so the current cycle is number cnt_q+1.
  assign expire_o = en_i && (cnt_q == W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    else if (en_i && !expire_o) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ysyx_23060061_exec_seq.sv
// Multi-cycle fetch/execute sequencer owning PC and IR; req/gnt/rvalid fetch, 2 cycles/instr at zero wait.
// Optional perf counters under YSYX_23060061_PERF_EN; otherwise perf ports read zero.
module ysyx_23060061_exec_seq
  import ysyx_23060061_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  input  logic [31:0] next_pc,
  input  logic        rf_wen_req,
  input  logic        ebreak,
  output logic        rf_wen,
  output logic        halted,
  output logic        fetch_err,
  output logic [63:0] perf_cycle,
  output logic [63:0] perf_instret
);

  state_e state_q, state_d;
  logic   capture, pc_wen, misaligned, expire, tmr_clr, tmr_en;
  logic   halted_q, halted_d, err_q, err_d;

  assign misaligned = |next_pc[1:0];

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        // A capture in the expiring cycle still wins over the timeout.
        if (imem_gnt && imem_rvalid) begin
          capture = 1'b1;
          state_d = S_EXEC;
        end else if (expire) state_d = S_ERR;
        else if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          capture = 1'b1;
          state_d = S_EXEC;
        end else if (expire) state_d = S_ERR;
      end
      S_EXEC: begin
        if (ebreak) state_d = S_HALT;
        else if (misaligned) state_d = S_ERR;
        else state_d = S_REQ;
      end
      default: state_d = state_q;
    endcase
  end

  assign pc_wen   = (state_q == S_EXEC) && !ebreak && !misaligned;
  assign tmr_clr  = (state_d == S_REQ) && (state_q != S_REQ);
  assign tmr_en   = (state_q == S_REQ) || (state_q == S_WAIT);
  assign halted_d = halted_q || (state_d == S_HALT);
  assign err_d    = err_q || (state_d == S_ERR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  ysyx_23060061_Reg #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc_reg (
    .clk_i(clk), .rst_ni(rst), .wen_i(pc_wen), .din_i(next_pc), .dout_o(pc)
  );

  ysyx_23060061_Reg #(.WIDTH(32), .RESET_VAL(NOP_INST)) u_ir_reg (
    .clk_i(clk), .rst_ni(rst), .wen_i(capture), .din_i(imem_rdata), .dout_o(inst)
  );

  ysyx_23060061_fetch_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk_i(clk), .rst_ni(rst), .clr_i(tmr_clr), .en_i(tmr_en), .expire_o(expire)
  );

  // Request is decoded straight from state so an async reset drops it immediately.
  assign imem_req   = (state_q == S_REQ);
  assign imem_addr  = pc;
  assign inst_valid = (state_q == S_EXEC);
  assign rf_wen     = (state_q == S_EXEC) && rf_wen_req && !ebreak;
  assign halted     = halted_q;
  assign fetch_err  = err_q;

`ifdef YSYX_23060061_PERF_EN
  logic [63:0] cycle_q, instret_q;
  logic        cyc_inc, ret_inc;

  // The halting/faulting cycle is excluded, matching instret skipping the ebreak.
  assign cyc_inc = (state_q != S_HALT) && (state_q != S_ERR) &&
                   (state_d != S_HALT) && (state_d != S_ERR);
  assign ret_inc = (state_q == S_EXEC) && !ebreak;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q   <= 64'd0;
      instret_q <= 64'd0;
    end else begin
      if (cyc_inc) cycle_q <= cycle_q + 64'd1;
      if (ret_inc) instret_q <= instret_q + 64'd1;
    end
  end

  assign perf_cycle   = cycle_q;
  assign perf_instret = instret_q;
`else
  assign perf_cycle   = 64'd0;
  assign perf_instret = 64'd0;
`endif

endmodule
